// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame
// Purpose  : Oversampled UART receive deserializer. Synchronizes the serial
//            line, qualifies the start bit at mid-bit, samples WIDTH data
//            bits LSB-first, then the parity bit and the stop bit. Hands the
//            locally computed parity and the received parity bit to the
//            downstream parity checker with a one-cycle par_en strobe.
// Ports    : clk        - system clock
//            rst        - asynchronous reset, active-high
//            baud_tick  - one-cycle pulse at OVERSAMPLE x baud rate
//            rx         - asynchronous serial line, idle high
//            data_out   - last received data word (LSB = first bit on line)
//            data_valid - one-cycle pulse, frame received with good stop bit
//            par_calc   - parity a correct transmitter would send for data_out
//            par_bit    - parity bit sampled from the line
//            par_en     - one-cycle strobe, par_calc/par_bit valid
//            frame_err  - one-cycle pulse, stop bit sampled low
//            busy       - high in every state except IDLE
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame #(
    parameter int WIDTH      = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             baud_tick,
    input  logic             rx,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             par_calc,
    output logic             par_bit,
    output logic             par_en,
    output logic             frame_err,
    output logic             busy
);

    localparam int c_tw = $clog2(OVERSAMPLE);
    localparam int c_bw = $clog2(WIDTH + 1);

    localparam logic [c_tw-1:0] c_tick_half = c_tw'(OVERSAMPLE / 2 - 1);
    localparam logic [c_tw-1:0] c_tick_last = c_tw'(OVERSAMPLE - 1);
    localparam logic [c_bw-1:0] c_bit_last  = c_bw'(WIDTH - 1);
    localparam logic            c_par_odd   = (PARITY_ODD != 0);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_parity = 3'd3;
    localparam logic [2:0] c_st_stop   = 3'd4;
    localparam logic [2:0] c_st_wait   = 3'd5;

    logic            r_rx_meta;
    logic            r_rx_s;
    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [c_tw-1:0] r_tick_cnt;
    logic [c_bw-1:0] r_bit_cnt;
    logic [WIDTH-1:0] r_data;
    logic            r_par_calc;
    logic            r_par_bit;
    logic            r_par_en;
    logic            r_data_valid;
    logic            r_frame_err;

    logic            w_cnt_last;
    logic            w_sample_data;
    logic            w_sample_par;
    logic            w_stop_good;
    logic            w_stop_bad;
    logic            w_busy;

    // Two-flop synchronizer; resets to the idle line level so a reset never
    // looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_cnt_last = (r_tick_cnt == c_tick_last);

    // ------------------------------------------------------------------
    // FSM: next-state logic (every transition is qualified by baud_tick)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (baud_tick) begin
            case (r_state)
                c_st_idle: begin
                    if (!r_rx_s) w_state_nxt = c_st_start;
                end
                c_st_start: begin
                    // Mid-bit re-check rejects glitches shorter than half a bit.
                    if (r_tick_cnt == c_tick_half)
                        w_state_nxt = r_rx_s ? c_st_idle : c_st_data;
                end
                c_st_data: begin
                    if (w_cnt_last && (r_bit_cnt == c_bit_last))
                        w_state_nxt = c_st_parity;
                end
                c_st_parity: begin
                    if (w_cnt_last) w_state_nxt = c_st_stop;
                end
                c_st_stop: begin
                    if (w_cnt_last)
                        w_state_nxt = r_rx_s ? c_st_idle : c_st_wait;
                end
                c_st_wait: begin
                    // A held-low line (break) must release before re-arming.
                    if (r_rx_s) w_state_nxt = c_st_idle;
                end
                default: w_state_nxt = c_st_idle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output / event decode
    // ------------------------------------------------------------------
    always_comb begin
        w_busy        = (r_state != c_st_idle);
        w_sample_data = baud_tick && w_cnt_last && (r_state == c_st_data);
        w_sample_par  = baud_tick && w_cnt_last && (r_state == c_st_parity);
        w_stop_good   = baud_tick && w_cnt_last && (r_state == c_st_stop) &&  r_rx_s;
        w_stop_bad    = baud_tick && w_cnt_last && (r_state == c_st_stop) && !r_rx_s;
    end

    // Tick counter restarts on every state change and after each data bit;
    // it only runs in the states that time a bit period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (baud_tick) begin
            if ((w_state_nxt != r_state) || w_sample_data) begin
                r_tick_cnt <= '0;
            end else if ((r_state == c_st_start) || (r_state == c_st_data) ||
                         (r_state == c_st_parity) || (r_state == c_st_stop)) begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= '0;
        end else if (baud_tick) begin
            if ((r_state == c_st_start) && (w_state_nxt == c_st_data)) begin
                r_bit_cnt <= '0;
            end else if (w_sample_data) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    // Data bits land directly in their final position, so data_out is only
    // coherent once the last bit is in (at par_en / data_valid).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w_sample_data && (r_bit_cnt == c_bw'(i))) begin
                    r_data[i] <= r_rx_s;
                end
            end
        end
    end

    // Parity values and the strobes are registered together so the checker
    // sees par_calc/par_bit stable in the same cycle par_en is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_calc   <= c_par_odd;
            r_par_bit    <= 1'b1;
            r_par_en     <= 1'b0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            if (w_sample_par) begin
                r_par_bit  <= r_rx_s;
                r_par_calc <= (^r_data) ^ c_par_odd;
            end
            r_par_en     <= w_sample_par;
            r_data_valid <= w_stop_good;
            r_frame_err  <= w_stop_bad;
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_data_valid;
    assign par_calc   = r_par_calc;
    assign par_bit    = r_par_bit;
    assign par_en     = r_par_en;
    assign frame_err  = r_frame_err;
    assign busy       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_frame
// Purpose  : Self-checking bench for uart_rx_frame. Two instances (even and
//            odd parity) share one serial line. A frame-level model records
//            every frame sent; a compare process matches each par_en,
//            data_valid and frame_err strobe against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame;

    localparam int W  = 8;
    localparam int OS = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic baud_tick = 1'b0;
    logic rx = 1'b1;

    logic [W-1:0] dout [2];
    logic dv [2];
    logic pc [2];
    logic pb [2];
    logic pe [2];
    logic fe [2];
    logic bs [2];

    uart_rx_frame #(.WIDTH(W), .OVERSAMPLE(OS), .PARITY_ODD(0)) u_even (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx),
        .data_out(dout[0]), .data_valid(dv[0]), .par_calc(pc[0]),
        .par_bit(pb[0]), .par_en(pe[0]), .frame_err(fe[0]), .busy(bs[0])
    );

    uart_rx_frame #(.WIDTH(W), .OVERSAMPLE(OS), .PARITY_ODD(1)) u_odd (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx),
        .data_out(dout[1]), .data_valid(dv[1]), .par_calc(pc[1]),
        .par_bit(pb[1]), .par_en(pe[1]), .frame_err(fe[1]), .busy(bs[1])
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit tick_all = 1'b1;

    // Frame-level model: what was put on the line, in order.
    logic [W-1:0] f_data [$];
    bit           f_par  [$];
    bit           f_stop [$];

    int           npe [2];
    int           nend [2];
    int           ndv [2];
    int           nfe [2];
    logic [W-1:0] last_do [2];
    logic         last_pc [2];
    logic         last_pb [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Tick generator: every clock, or a random 1-in-3 rate.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            baud_tick = tick_all ? 1'b1 : ($urandom_range(0, 2) == 0);
        end
    end

    task automatic wait_ticks(input int n);
        int c = 0;
        while (c < n) begin
            @(posedge clk);
            if (baud_tick) c++;
        end
    endtask

    task automatic send_bit(input bit b, input int n);
        #1 rx = b;
        wait_ticks(n);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input bit p, input bit s);
        f_data.push_back(d);
        f_par.push_back(p);
        f_stop.push_back(s);
        send_bit(1'b0, OS);
        for (int i = 0; i < W; i++) send_bit(d[i], OS);
        send_bit(p, OS);
        send_bit(s, OS);
    endtask

    task automatic check_done();
        for (int k = 0; k < 2; k++)
            chk($sformatf("frames_closed_dut%0d", k), nend[k], f_data.size());
    endtask

    task automatic check_busy(input logic exp);
        for (int k = 0; k < 2; k++)
            chk($sformatf("busy_dut%0d", k), {31'd0, bs[k]}, {31'd0, exp});
    endtask

    task automatic check_reset_vals();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_data_out_dut%0d", k), dout[k], 0);
            chk($sformatf("rst_strobes_dut%0d", k), {pe[k], dv[k], fe[k]}, 0);
            chk($sformatf("rst_par_calc_dut%0d", k), pc[k], k);
            chk($sformatf("rst_par_bit_dut%0d", k), pb[k], 1);
            chk($sformatf("rst_busy_dut%0d", k), bs[k], 0);
        end
    endtask

    // Compare process: every strobe is matched against the frame model.
    initial begin
        int j;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int k = 0; k < 2; k++) begin
                    if (pe[k] || dv[k] || fe[k])
                        chk($sformatf("strobe_exclusive_dut%0d", k),
                            int'(pe[k]) + int'(dv[k]) + int'(fe[k]), 1);
                    if (pe[k]) begin
                        j = npe[k];
                        if (j >= f_data.size() || j != nend[k]) begin
                            total++; bad++;
                            $display("FAIL par_en_unexpected dut%0d: strobe %0d, frames sent %0d closed %0d",
                                     k, j, f_data.size(), nend[k]);
                        end else begin
                            chk($sformatf("par_calc_dut%0d", k), pc[k], (^f_data[j]) ^ bit'(k));
                            chk($sformatf("par_bit_dut%0d", k), pb[k], f_par[j]);
                            chk($sformatf("data_at_par_en_dut%0d", k), dout[k], f_data[j]);
                        end
                        npe[k]++;
                        last_pc[k] = pc[k];
                        last_pb[k] = pb[k];
                        last_do[k] = dout[k];
                    end
                    if (dv[k] || fe[k]) begin
                        j = nend[k];
                        if (j >= f_data.size() || npe[k] != j + 1) begin
                            total++; bad++;
                            $display("FAIL end_strobe_unexpected dut%0d: dv=%0b fe=%0b frame %0d, par_en seen %0d",
                                     k, dv[k], fe[k], j, npe[k]);
                        end else begin
                            chk($sformatf("stop_kind_dut%0d", k), dv[k], f_stop[j]);
                            if (dv[k]) chk($sformatf("data_out_dut%0d", k), dout[k], f_data[j]);
                        end
                        nend[k]++;
                        if (dv[k]) begin
                            ndv[k]++;
                            last_do[k] = dout[k];
                        end
                        if (fe[k]) nfe[k]++;
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] d;
        bit p, s;
        int gap;

        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_reset_vals();
        @(posedge clk);
        #2 rst = 1'b0;
        wait_ticks(4);

        // 0xA5 with correct even parity, good stop.
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_ticks(4);
        check_done();
        chk("lit_a5_par_calc", last_pc[0], 0);
        chk("lit_a5_par_bit", last_pb[0], 0);
        chk("lit_a5_data", last_do[0], 8'hA5);
        chk("lit_a5_dv_count", ndv[0], 1);
        chk("lit_a5_odd_par_calc", last_pc[1], 1);

        // Same data, wrong parity bit: still delivered.
        send_frame(8'hA5, 1'b1, 1'b1);
        wait_ticks(4);
        check_done();
        chk("lit_a5p1_par_calc", last_pc[0], 0);
        chk("lit_a5p1_par_bit", last_pb[0], 1);
        chk("lit_a5p1_dv_count", ndv[0], 2);

        // Odd-parity instance, data 0x01.
        send_frame(8'h01, 1'b0, 1'b1);
        wait_ticks(4);
        check_done();
        chk("lit_01_odd_par_calc", last_pc[1], 0);
        chk("lit_01_odd_par_bit", last_pb[1], 0);
        chk("lit_01_odd_data", last_do[1], 8'h01);

        // Short glitch: no strobes, busy drops.
        send_bit(1'b0, 4);
        send_bit(1'b1, 9);
        repeat (3) @(posedge clk);
        check_busy(1'b0);
        check_done();

        // Framing error followed by a 40-tick break.
        send_frame(8'h3C, 1'b0, 1'b0);
        send_bit(1'b0, 40);
        check_busy(1'b1);
        send_bit(1'b1, 4);
        repeat (3) @(posedge clk);
        check_busy(1'b0);
        check_done();
        chk("lit_3c_fe_count", nfe[0], 1);
        chk("lit_3c_dv_count", ndv[0], 3);
        send_frame(8'h55, 1'b0, 1'b1);
        wait_ticks(4);
        check_done();
        chk("lit_55_data", last_do[0], 8'h55);

        // Reset while receiving data bit 3.
        send_bit(1'b0, OS);
        send_bit(1'b1, OS);
        send_bit(1'b0, OS);
        send_bit(1'b1, OS);
        send_bit(1'b0, OS / 2);
        #3 rst = 1'b1;
        #1 check_reset_vals();
        rx = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        wait_ticks(4);
        send_frame(8'hFF, 1'b0, 1'b1);
        wait_ticks(4);
        check_done();
        chk("lit_ff_par_calc", last_pc[0], 0);
        chk("lit_ff_data", last_do[0], 8'hFF);
        chk("lit_ff_odd_par_calc", last_pc[1], 1);

        // Randomized frames: dense ticks, then sparse random ticks.
        for (int pass = 0; pass < 2; pass++) begin
            tick_all = (pass == 0);
            for (int n = 0; n < 12; n++) begin
                d = W'($urandom);
                p = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
                s = ($urandom_range(0, 4) != 0);
                send_frame(d, p, s);
                if (!s) begin
                    send_bit(1'b0, $urandom_range(0, 30));
                    send_bit(1'b1, 4 + $urandom_range(0, 3));
                    check_done();
                end else begin
                    check_done();
                    gap = $urandom_range(0, 3);
                    if (gap > 0) send_bit(1'b1, gap);
                end
            end
        end
        send_bit(1'b1, 4);
        repeat (3) @(posedge clk);
        check_done();
        for (int k = 0; k < 2; k++)
            chk($sformatf("par_en_count_dut%0d", k), npe[k], f_data.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
